// File: rtl/decode_pkg.sv
// Shared decode vocabulary: RV32I opcodes, immediate formats, ALU control encodings
// and the packed control bundle carried in the decode output slot.
package decode_pkg;

  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111,
    AUIPC  = 7'b0010111,
    LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_t;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef struct packed {
    logic wr_enable;
    logic mem_to_reg;
    logic alu_src;
    logic mem_write;
    logic jump;
    logic jal_src;
    logic branch;
    logic illegal;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one write landing on the clock edge.
// x0 and indices >= NREGS read as zero and ignore writes; synchronous reset clears all entries.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NREGS_W);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && in_range(waddr)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = in_range(raddr1) ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = in_range(raddr2) ? regs[raddr2[AW-1:0]] : '0;

endmodule

// File: rtl/stage_decode_pipe.sv
// RV32I/E decode stage with one registered output slot (1-cycle latency); fetch_ready drops only
// while the slot is full and execute stalls, and a stalled slot snoops write-back into its operands.
module stage_decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_instr,
  input  logic [XLEN-1:0] fetch_instr_addr,
  input  logic [XLEN-1:0] fetch_instr_addr_plus,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            decode_valid,
  output logic [XLEN-1:0] decode_instr_addr,
  output logic [XLEN-1:0] decode_instr_addr_plus,
  output logic [XLEN-1:0] rs_data1,
  output logic [XLEN-1:0] rs_data2,
  output logic [4:0]      decode_rd,
  output logic [3:0]      decode_alu_ctrl,
  output logic [XLEN-1:0] decode_imm,
  output logic            decode_alu_src,
  output logic            decode_wr_enable,
  output logic            decode_mem_to_reg,
  output logic            decode_mem_write,
  output logic            decode_jump,
  output logic            decode_jal_src,
  output logic            decode_branch,
  output logic            decode_illegal,
  input  logic            wb_wr_enable,
  input  logic [4:0]      wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data
);

  localparam logic [5:0] NREGS_W = 6'(NREGS);

  opcode_t         opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  ctrl_t           ctrl_d, ctrl_q;
  imm_fmt_t        fmt;
  logic [3:0]      alu_ctrl_d;
  logic            use_rd, use_rs1, use_rs2, known_op, bad_idx;
  logic [4:0]      ra1, ra2, rs1_q, rs2_q;
  logic [31:0]     imm32;
  logic [XLEN-1:0] rf_rd1, rf_rd2, op1_d, op2_d;
  logic            xfer;

  function automatic logic idx_ok(input logic [4:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  function automatic logic wb_hits(input logic [4:0] a);
    return wb_wr_enable && (wb_wr_addr == a) && (a != 5'd0) && idx_ok(a);
  endfunction

  assign opcode = opcode_t'(fetch_instr[6:0]);
  assign funct3 = fetch_instr[14:12];
  assign rd_f   = fetch_instr[11:7];
  assign rs1_f  = fetch_instr[19:15];
  assign rs2_f  = fetch_instr[24:20];

  always_comb begin
    ctrl_d     = '0;
    alu_ctrl_d = ALU_ADD;
    fmt        = IMM_NONE;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    known_op   = 1'b1;
    case (opcode)
      R_TYPE: begin
        ctrl_d.wr_enable = 1'b1;
        alu_ctrl_d = {fetch_instr[30], funct3};
        {use_rd, use_rs1, use_rs2} = 3'b111;
      end
      I_TYPE: begin
        ctrl_d.wr_enable = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_ctrl_d = {(funct3 == F3_SRL_SRA) & fetch_instr[30], funct3};
        fmt = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? IMM_SHAMT : IMM_I;
        {use_rd, use_rs1} = 2'b11;
      end
      LOAD: begin
        ctrl_d.wr_enable  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        alu_ctrl_d = {1'b0, funct3};
        fmt = IMM_I;
        {use_rd, use_rs1} = 2'b11;
      end
      STORE: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        alu_ctrl_d = {1'b0, funct3};
        fmt = IMM_S;
        {use_rs1, use_rs2} = 2'b11;
      end
      BRANCH: begin
        ctrl_d.branch = 1'b1;
        alu_ctrl_d = {1'b0, funct3};
        fmt = IMM_B;
        {use_rs1, use_rs2} = 2'b11;
      end
      JAL: begin
        ctrl_d.wr_enable = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.jal_src   = 1'b1;
        fmt = IMM_J;
        use_rd = 1'b1;
      end
      JALR: begin
        ctrl_d.wr_enable = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.jump      = 1'b1;
        alu_ctrl_d = {1'b0, funct3};
        fmt = IMM_I;
        {use_rd, use_rs1} = 2'b11;
      end
      // AUIPC's PC operand is selected downstream; both read rs1 as zero here.
      LUI, AUIPC: begin
        ctrl_d.wr_enable = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        fmt = IMM_U;
        use_rd = 1'b1;
      end
      default: known_op = 1'b0;
    endcase

    bad_idx = (use_rd && !idx_ok(rd_f)) || (use_rs1 && !idx_ok(rs1_f)) ||
              (use_rs2 && !idx_ok(rs2_f));
    if (!known_op || bad_idx) begin
      ctrl_d.illegal   = 1'b1;
      ctrl_d.wr_enable = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.jump      = 1'b0;
      ctrl_d.branch    = 1'b0;
    end
  end

  assign ra1   = use_rs1 ? rs1_f : 5'd0;
  assign ra2   = use_rs2 ? rs2_f : 5'd0;
  assign imm32 = gen_imm(fetch_instr, fmt);

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wr_enable),
    .waddr  (wb_wr_addr),
    .wdata  (wb_wr_data),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  assign op1_d = (WB_BYPASS && wb_hits(ra1)) ? wb_wr_data : rf_rd1;
  assign op2_d = (WB_BYPASS && wb_hits(ra2)) ? wb_wr_data : rf_rd2;

  assign fetch_ready = !decode_valid || ex_ready;
  assign xfer        = fetch_valid && fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      decode_valid           <= 1'b0;
      decode_instr_addr      <= '0;
      decode_instr_addr_plus <= '0;
      rs_data1               <= '0;
      rs_data2               <= '0;
      decode_rd              <= '0;
      decode_alu_ctrl        <= '0;
      decode_imm             <= '0;
      ctrl_q                 <= '0;
      rs1_q                  <= '0;
      rs2_q                  <= '0;
    end else if (flush) begin
      decode_valid <= 1'b0;
    end else if (xfer) begin
      decode_valid           <= 1'b1;
      decode_instr_addr      <= fetch_instr_addr;
      decode_instr_addr_plus <= fetch_instr_addr_plus;
      rs_data1               <= op1_d;
      rs_data2               <= op2_d;
      decode_rd              <= rd_f;
      decode_alu_ctrl        <= alu_ctrl_d;
      decode_imm             <= XLEN'($signed(imm32));
      ctrl_q                 <= ctrl_d;
      rs1_q                  <= ra1;
      rs2_q                  <= ra2;
    end else if (ex_ready) begin
      decode_valid <= 1'b0;
    end else if (decode_valid) begin
      // Held operands must track registers retired while execute is stalled.
      if (wb_hits(rs1_q)) rs_data1 <= wb_wr_data;
      if (wb_hits(rs2_q)) rs_data2 <= wb_wr_data;
    end
  end

  assign decode_wr_enable  = ctrl_q.wr_enable;
  assign decode_mem_to_reg = ctrl_q.mem_to_reg;
  assign decode_alu_src    = ctrl_q.alu_src;
  assign decode_mem_write  = ctrl_q.mem_write;
  assign decode_jump       = ctrl_q.jump;
  assign decode_jal_src    = ctrl_q.jal_src;
  assign decode_branch     = ctrl_q.branch;
  assign decode_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_stage_decode_pipe.sv
// Bench for stage_decode_pipe: directed scenarios plus a randomized stream checked
// against an instruction-level reference model (RV32I, bypass on) and two variant instances.
module tb_stage_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_valid, flush, ex_ready, wb_wr_enable;
  logic [31:0] fetch_instr, fetch_instr_addr, fetch_instr_addr_plus, wb_wr_data;
  logic [4:0]  wb_wr_addr;

  logic        fetch_ready, decode_valid, decode_alu_src, decode_wr_enable, decode_mem_to_reg;
  logic        decode_mem_write, decode_jump, decode_jal_src, decode_branch, decode_illegal;
  logic [31:0] decode_instr_addr, decode_instr_addr_plus, rs_data1, rs_data2, decode_imm;
  logic [4:0]  decode_rd;
  logic [3:0]  decode_alu_ctrl;

  logic        nb_fetch_ready, nb_valid, nb_alu_src, nb_wr_enable, nb_mem_to_reg;
  logic        nb_mem_write, nb_jump, nb_jal_src, nb_branch, nb_illegal;
  logic [31:0] nb_addr, nb_addr_plus, nb_rs_data1, nb_rs_data2, nb_imm;
  logic [4:0]  nb_rd;
  logic [3:0]  nb_alu_ctrl;

  logic        e_fetch_ready, e_valid, e_alu_src, e_wr_enable, e_mem_to_reg;
  logic        e_mem_write, e_jump, e_jal_src, e_branch, e_illegal;
  logic [31:0] e_addr, e_addr_plus, e_rs_data1, e_rs_data2, e_imm;
  logic [4:0]  e_rd;
  logic [3:0]  e_alu_ctrl;

  stage_decode_pipe #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_instr_addr(fetch_instr_addr),
    .fetch_instr_addr_plus(fetch_instr_addr_plus), .flush(flush), .ex_ready(ex_ready),
    .decode_valid(decode_valid), .decode_instr_addr(decode_instr_addr),
    .decode_instr_addr_plus(decode_instr_addr_plus), .rs_data1(rs_data1), .rs_data2(rs_data2),
    .decode_rd(decode_rd), .decode_alu_ctrl(decode_alu_ctrl), .decode_imm(decode_imm),
    .decode_alu_src(decode_alu_src), .decode_wr_enable(decode_wr_enable),
    .decode_mem_to_reg(decode_mem_to_reg), .decode_mem_write(decode_mem_write),
    .decode_jump(decode_jump), .decode_jal_src(decode_jal_src), .decode_branch(decode_branch),
    .decode_illegal(decode_illegal), .wb_wr_enable(wb_wr_enable), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data));

  stage_decode_pipe #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(nb_fetch_ready),
    .fetch_instr(fetch_instr), .fetch_instr_addr(fetch_instr_addr),
    .fetch_instr_addr_plus(fetch_instr_addr_plus), .flush(flush), .ex_ready(ex_ready),
    .decode_valid(nb_valid), .decode_instr_addr(nb_addr), .decode_instr_addr_plus(nb_addr_plus),
    .rs_data1(nb_rs_data1), .rs_data2(nb_rs_data2), .decode_rd(nb_rd),
    .decode_alu_ctrl(nb_alu_ctrl), .decode_imm(nb_imm), .decode_alu_src(nb_alu_src),
    .decode_wr_enable(nb_wr_enable), .decode_mem_to_reg(nb_mem_to_reg),
    .decode_mem_write(nb_mem_write), .decode_jump(nb_jump), .decode_jal_src(nb_jal_src),
    .decode_branch(nb_branch), .decode_illegal(nb_illegal), .wb_wr_enable(wb_wr_enable),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data));

  stage_decode_pipe #(.XLEN(32), .NREGS(16), .WB_BYPASS(1'b1)) dut_e (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(e_fetch_ready),
    .fetch_instr(fetch_instr), .fetch_instr_addr(fetch_instr_addr),
    .fetch_instr_addr_plus(fetch_instr_addr_plus), .flush(flush), .ex_ready(ex_ready),
    .decode_valid(e_valid), .decode_instr_addr(e_addr), .decode_instr_addr_plus(e_addr_plus),
    .rs_data1(e_rs_data1), .rs_data2(e_rs_data2), .decode_rd(e_rd),
    .decode_alu_ctrl(e_alu_ctrl), .decode_imm(e_imm), .decode_alu_src(e_alu_src),
    .decode_wr_enable(e_wr_enable), .decode_mem_to_reg(e_mem_to_reg),
    .decode_mem_write(e_mem_write), .decode_jump(e_jump), .decode_jal_src(e_jal_src),
    .decode_branch(e_branch), .decode_illegal(e_illegal), .wb_wr_enable(wb_wr_enable),
    .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] pc, pcp, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        alu_src, wr, m2r, mw, jump, jal, br, ill;
  } exp_t;

  localparam logic [31:0] ADDI_X1_M5  = 32'hFFB00093;
  localparam logic [31:0] ADDI_X2_7   = 32'h00700113;
  localparam logic [31:0] ADDI_X3_9   = 32'h00900193;
  localparam logic [31:0] ADDI_X6_X5  = 32'h00028313;
  localparam logic [31:0] ADDI_X2_X1  = 32'h00008113;
  localparam logic [31:0] BEQ_M8      = 32'hFE000CE3;
  localparam logic [31:0] JAL_X1_2048 = 32'h001000EF;
  localparam logic [31:0] ADD_X20     = 32'h00208A33;
  localparam logic [31:0] BAD_OP      = 32'h0000007F;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; fetch_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    wb_wr_enable = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid = 1'b1; fetch_instr = ins; fetch_instr_addr = pc; fetch_instr_addr_plus = pc + 4;
  endtask

  // Instruction-level reference: fields straight from the ISA encoding tables.
  function automatic void ref_decode(input logic [31:0] ins, output exp_t e,
                                     output logic [4:0] a1, output logic [4:0] a2);
    logic [2:0] f3;
    f3 = ins[14:12];
    e = '0; a1 = '0; a2 = '0;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin e.wr = 1; e.alu = {ins[30], f3}; a1 = ins[19:15]; a2 = ins[24:20]; end
      7'h13: begin
        e.wr = 1; e.alu_src = 1; a1 = ins[19:15];
        if (f3 == 3'd1 || f3 == 3'd5) e.imm = 32'(ins[24:20]);
        else e.imm = {{20{ins[31]}}, ins[31:20]};
        e.alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
      end
      7'h03: begin
        e.wr = 1; e.m2r = 1; e.alu_src = 1; a1 = ins[19:15];
        e.imm = {{20{ins[31]}}, ins[31:20]}; e.alu = {1'b0, f3};
      end
      7'h23: begin
        e.alu_src = 1; e.mw = 1; a1 = ins[19:15]; a2 = ins[24:20];
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.alu = {1'b0, f3};
      end
      7'h63: begin
        e.br = 1; a1 = ins[19:15]; a2 = ins[24:20]; e.alu = {1'b0, f3};
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h6F: begin
        e.wr = 1; e.jump = 1; e.jal = 1;
        e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin
        e.wr = 1; e.alu_src = 1; e.jump = 1; a1 = ins[19:15];
        e.imm = {{20{ins[31]}}, ins[31:20]}; e.alu = {1'b0, f3};
      end
      7'h37, 7'h17: begin e.wr = 1; e.alu_src = 1; e.imm = {ins[31:12], 12'h000}; end
      default: e.ill = 1;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; fetch_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    wb_wr_enable = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
    fetch_instr = '0; fetch_instr_addr = '0; fetch_instr_addr_plus = '0;
    tick(); tick();
    n_checks++;
    if ({decode_valid, rs_data1, rs_data2, decode_imm, decode_rd, decode_wr_enable,
         decode_illegal, decode_instr_addr, decode_alu_ctrl} !== '0)
      $display("FAIL reset_outputs: got v=%b rs1=%h imm=%h rd=%0d wr=%b, required all zero",
               decode_valid, rs_data1, decode_imm, decode_rd, decode_wr_enable);
    else n_pass++;
    idle();
    #1;
    n_checks++;
    if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready: got %b required 1", fetch_ready);
    else n_pass++;
  endtask

  task automatic test_addi();
    idle(); send(ADDI_X1_M5, 32'h100); tick(); idle();
    n_checks++;
    if ({decode_valid, decode_imm, decode_alu_src, decode_wr_enable, decode_rd, decode_alu_ctrl,
         decode_instr_addr, decode_instr_addr_plus} !==
        {1'b1, 32'hFFFFFFFB, 1'b1, 1'b1, 5'd1, 4'd0, 32'h100, 32'h104})
      $display("FAIL addi: got v=%b imm=%h src=%b wr=%b rd=%0d pc=%h, required 1 fffffffb 1 1 1 100",
               decode_valid, decode_imm, decode_alu_src, decode_wr_enable, decode_rd,
               decode_instr_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (decode_valid !== 1'b0) $display("FAIL addi_drain: got valid %b required 0", decode_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    idle(); send(ADDI_X2_7, 32'h300); tick();
    ex_ready = 1'b0; send(ADDI_X3_9, 32'h304);
    #1;
    n_checks++;
    if (fetch_ready !== 1'b0) $display("FAIL stall_ready: got %b required 0", fetch_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({decode_valid, decode_rd, decode_imm, decode_instr_addr, fetch_ready} !==
          {1'b1, 5'd2, 32'd7, 32'h300, 1'b0})
        $display("FAIL stall_hold[%0d]: got v=%b rd=%0d imm=%h pc=%h rdy=%b, required 1 2 7 300 0",
                 i, decode_valid, decode_rd, decode_imm, decode_instr_addr, fetch_ready);
      else n_pass++;
    end
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (fetch_ready !== 1'b1) $display("FAIL stall_release: got %b required 1", fetch_ready);
    else n_pass++;
    tick(); fetch_valid = 1'b0;
    n_checks++;
    if ({decode_valid, decode_rd, decode_imm, decode_instr_addr} !== {1'b1, 5'd3, 32'd9, 32'h304})
      $display("FAIL stall_next: got v=%b rd=%0d imm=%h pc=%h, required 1 3 9 304",
               decode_valid, decode_rd, decode_imm, decode_instr_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (decode_valid !== 1'b0) $display("FAIL stall_drain: got %b required 0", decode_valid);
    else n_pass++;
  endtask

  task automatic test_bypass_snoop();
    idle(); wb_wr_enable = 1'b1; wb_wr_addr = 5'd5; wb_wr_data = 32'h1111; tick();
    send(ADDI_X6_X5, 32'h400); wb_wr_data = 32'h1234; tick();
    fetch_valid = 1'b0;
    n_checks++;
    if ({rs_data1, nb_rs_data1} !== {32'h1234, 32'h1111})
      $display("FAIL bypass: got bypass=%h nobypass=%h, required 1234 1111", rs_data1, nb_rs_data1);
    else n_pass++;
    ex_ready = 1'b0; wb_wr_data = 32'hBEEF; tick();
    n_checks++;
    if ({rs_data1, nb_rs_data1, decode_valid} !== {32'hBEEF, 32'hBEEF, 1'b1})
      $display("FAIL snoop: got bypass=%h nobypass=%h v=%b, required beef beef 1",
               rs_data1, nb_rs_data1, decode_valid);
    else n_pass++;
    idle(); tick();
  endtask

  task automatic test_branch_jal();
    idle(); send(BEQ_M8, 32'h500); tick();
    send(JAL_X1_2048, 32'h504);
    n_checks++;
    if ({decode_valid, decode_branch, decode_imm, decode_wr_enable, decode_jump} !==
        {1'b1, 1'b1, 32'hFFFFFFF8, 1'b0, 1'b0})
      $display("FAIL beq: got v=%b br=%b imm=%h wr=%b, required 1 1 fffffff8 0",
               decode_valid, decode_branch, decode_imm, decode_wr_enable);
    else n_pass++;
    tick(); fetch_valid = 1'b0;
    n_checks++;
    if ({decode_valid, decode_jump, decode_jal_src, decode_imm, decode_wr_enable, decode_branch} !==
        {1'b1, 1'b1, 1'b1, 32'h800, 1'b1, 1'b0})
      $display("FAIL jal: got v=%b j=%b jal=%b imm=%h wr=%b, required 1 1 1 800 1",
               decode_valid, decode_jump, decode_jal_src, decode_imm, decode_wr_enable);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    idle(); send(ADDI_X2_7, 32'h600); flush = 1'b1; tick(); idle();
    n_checks++;
    if (decode_valid !== 1'b0) $display("FAIL flush_xfer: got valid %b required 0", decode_valid);
    else n_pass++;
    send(ADDI_X2_7, 32'h600); tick();
    fetch_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1; tick(); idle();
    n_checks++;
    if (decode_valid !== 1'b0) $display("FAIL flush_held: got valid %b required 0", decode_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    idle(); wb_wr_enable = 1'b1; wb_wr_addr = 5'd1; wb_wr_data = 32'h55; tick();
    wb_wr_enable = 1'b0; send(ADDI_X2_X1, 32'h700); tick();
    fetch_valid = 1'b0; ex_ready = 1'b0; tick();
    n_checks++;
    if ({decode_valid, rs_data1} !== {1'b1, 32'h55})
      $display("FAIL pre_reset_hold: got v=%b rs1=%h, required 1 55", decode_valid, rs_data1);
    else n_pass++;
    rst = 1'b1; tick(); idle();
    n_checks++;
    if ({decode_valid, rs_data1, decode_imm, decode_rd, decode_wr_enable, decode_alu_src,
         decode_instr_addr, decode_instr_addr_plus} !== '0)
      $display("FAIL reset_mid_stall: got v=%b rs1=%h rd=%0d wr=%b pc=%h, required all zero",
               decode_valid, rs_data1, decode_rd, decode_wr_enable, decode_instr_addr);
    else n_pass++;
    send(ADDI_X2_X1, 32'h704); tick(); fetch_valid = 1'b0;
    n_checks++;
    if ({decode_valid, rs_data1} !== {1'b1, 32'h0})
      $display("FAIL reset_clears_x1: got v=%b rs1=%h, required 1 0", decode_valid, rs_data1);
    else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    idle(); send(ADD_X20, 32'h800); tick();
    send(BAD_OP, 32'h804);
    n_checks++;
    if ({e_valid, e_illegal, e_wr_enable, decode_illegal, decode_wr_enable} !== 5'b11001)
      $display("FAIL rv32e_add_x20: got e_v=%b e_ill=%b e_wr=%b i_ill=%b i_wr=%b, required 1 1 0 0 1",
               e_valid, e_illegal, e_wr_enable, decode_illegal, decode_wr_enable);
    else n_pass++;
    tick(); fetch_valid = 1'b0;
    n_checks++;
    if ({decode_valid, decode_illegal, decode_wr_enable, decode_jump, decode_branch,
         decode_mem_write} !== 6'b110000)
      $display("FAIL bad_opcode: got v=%b ill=%b wr=%b j=%b br=%b mw=%b, required 1 1 0 0 0 0",
               decode_valid, decode_illegal, decode_wr_enable, decode_jump, decode_branch,
               decode_mem_write);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] ref_rf [32];
    logic [31:0] ins;
    exp_t        m_exp, n_exp, obs;
    logic        m_valid, n_valid, fr, xfer;
    logic [4:0]  m_a1, m_a2, n_a1, n_a2;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < 32; r++) ref_rf[r] = '0;
    m_valid = 1'b0; m_exp = '0; m_a1 = '0; m_a2 = '0;
    for (int c = 0; c < 800; c++) begin
      ins = $urandom();
      ins[6:0] = ($urandom_range(0, 11) == 0) ? 7'($urandom()) : ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) != 0) begin ins[19:18] = 2'b00; ins[24:23] = 2'b00; end
      fetch_valid = ($urandom_range(0, 9) < 7);
      ex_ready    = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      wb_wr_enable = $urandom_range(0, 1) == 1;
      wb_wr_addr   = 5'($urandom_range(0, 7));
      wb_wr_data   = $urandom();
      fetch_instr = ins; fetch_instr_addr = $urandom(); fetch_instr_addr_plus = fetch_instr_addr + 4;
      #1;
      fr = !m_valid || ex_ready;
      n_checks++;
      if (fetch_ready !== fr) $display("FAIL rand_ready[%0d]: got %b required %b", c, fetch_ready, fr);
      else n_pass++;
      xfer = fetch_valid && fr;
      n_valid = m_valid; n_exp = m_exp; n_a1 = m_a1; n_a2 = m_a2;
      if (flush) n_valid = 1'b0;
      else if (xfer) begin
        ref_decode(ins, n_exp, n_a1, n_a2);
        n_exp.pc = fetch_instr_addr; n_exp.pcp = fetch_instr_addr_plus;
        n_exp.rs1 = (n_a1 == 0) ? 32'h0 :
                    (wb_wr_enable && wb_wr_addr == n_a1) ? wb_wr_data : ref_rf[n_a1];
        n_exp.rs2 = (n_a2 == 0) ? 32'h0 :
                    (wb_wr_enable && wb_wr_addr == n_a2) ? wb_wr_data : ref_rf[n_a2];
        n_valid = 1'b1;
      end else if (ex_ready) n_valid = 1'b0;
      else if (m_valid && wb_wr_enable) begin
        if (m_a1 != 0 && wb_wr_addr == m_a1) n_exp.rs1 = wb_wr_data;
        if (m_a2 != 0 && wb_wr_addr == m_a2) n_exp.rs2 = wb_wr_data;
      end
      if (wb_wr_enable && wb_wr_addr != 0) ref_rf[wb_wr_addr] = wb_wr_data;
      tick();
      m_valid = n_valid; m_exp = n_exp; m_a1 = n_a1; m_a2 = n_a2;
      n_checks++;
      if (decode_valid !== m_valid)
        $display("FAIL rand_valid[%0d]: got %b required %b", c, decode_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        obs = {decode_instr_addr, decode_instr_addr_plus, rs_data1, rs_data2, decode_imm,
               decode_rd, decode_alu_ctrl, decode_alu_src, decode_wr_enable, decode_mem_to_reg,
               decode_mem_write, decode_jump, decode_jal_src, decode_branch, decode_illegal};
        n_checks++;
        if (obs !== m_exp)
          $display("FAIL rand_slot[%0d]: got %h required %h (instr %h)", c, obs, m_exp, ins);
        else n_pass++;
      end
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stall();
    test_bypass_snoop();
    test_branch_jal();
    test_flush();
    test_reset_mid_stall();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage_decode_pipe.md
Name: stage_decode_pipe

Overview:
Parametrised successor of the single-issue decode stage.
- Decodes the full RV32I/RV32E base set, with all immediate formats.
- Holds the register file, with optional write-back bypass.
- Adds a valid/ready handshake toward fetch and execute, plus flush.
- Sits between the fetch stage and the execute stage; one registered output slot, 1-cycle latency.

Parameters:
XLEN, 32, datapath and address width.
NREGS, 32, architectural register count; 32 = RV32I, 16 = RV32E.
WB_BYPASS, 1, 1 = same-cycle write-back data is forwarded onto register reads; 0 = no forwarding.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid  in  1  fetch offers an instruction
fetch_ready  out  1  decode accepts this cycle
fetch_instr  in  32  instruction word
fetch_instr_addr  in  XLEN  PC of instruction
fetch_instr_addr_plus  in  XLEN  PC+4
flush  in  1  kill the held slot and any incoming transfer (branch redirect)
ex_ready  in  1  execute accepts decode output
decode_valid  out  1  output slot holds a live instruction
decode_instr_addr  out  XLEN  registered PC
decode_instr_addr_plus  out  XLEN  registered PC+4
rs_data1  out  XLEN  operand 1
rs_data2  out  XLEN  operand 2
decode_rd  out  5  destination register
decode_alu_ctrl  out  4  {alt bit, funct3}
decode_imm  out  XLEN  sign-extended immediate
decode_alu_src  out  1  1 = ALU operand B is the immediate
decode_wr_enable  out  1  rd written at write-back
decode_mem_to_reg  out  1  load result selected at write-back
decode_mem_write  out  1  store
decode_jump  out  1  JAL or JALR
decode_jal_src  out  1  1 = JAL, 0 = JALR
decode_branch  out  1  conditional branch
decode_illegal  out  1  unsupported opcode or register index
wb_wr_enable  in  1  write-back enable
wb_wr_addr  in  5  write-back register
wb_wr_data  in  XLEN  write-back data

Behaviour:
- Reset: decode_valid and every decode_* output = 0, rs_data1/2 = 0, all registers = 0.
- fetch_ready = !decode_valid || ex_ready. This is combinational and has no dependence on fetch_valid.
- Transfer occurs when fetch_valid && fetch_ready. The next cycle, the slot holds the decoded instruction and decode_valid = 1.
- Slot empties when ex_ready is high and no transfer occurs.
- Stall: if decode_valid && !ex_ready, every output holds stable.
- Flush: decode_valid <= 0 on the next edge. Flush beats a simultaneous transfer, and that fetched instruction is dropped.
- Register file: one write port and two reads, captured at the transfer edge.
  - x0 always reads 0, and writes to it are ignored.
  - Write to index >= NREGS is ignored.
  - Write-back lands on the clock edge.
- WB_BYPASS=1: if wb writes rsN during the transfer cycle, the slot captures wb_wr_data.
- Snoop: regardless of WB_BYPASS, while the slot is stalled the held rs_data1/2 are overwritten by a matching wb write (rsN ≠ 0). Held source addresses are kept internally for this.
- Immediates, all sign-extended to XLEN:
  - I = instr[31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - Shifts: imm = shamt zero-extended.
- alu_ctrl alt bit = instr[30] for R-type and for SRLI/SRAI; 0 for other I-type; funct3 copied.
- Opcode controls (wr_en, mem_to_reg, alu_src, mem_write, jump, jal_src, branch):
  - R: 1,0,0,0,0,0,0
  - I-ALU: 1,0,1,0,0,0,0
  - LOAD: 1,1,1,0,0,0,0
  - STORE: 0,0,1,1,0,0,0
  - BRANCH: 0,0,0,0,0,0,1
  - JAL: 1,0,0,0,1,1,0
  - JALR: 1,0,1,0,1,0,0
  - LUI: 1,0,1,0,0,0,0 (alu_ctrl=ADD, rs1 forced 0)
  - AUIPC: 1,0,1,0,0,0,0 (ALU operand A = PC is chosen downstream by opcode, flagged by alu_ctrl=ADD with rs1 field ignored)
- Illegal: unknown opcode, or (NREGS=16 and any used rd/rs index >= 16).
  - decode_illegal = 1.
  - wr_enable, mem_write, jump and branch are forced to 0.
  - The slot is still valid, so execute can trap.

Decomposition:
- Package decode_pkg:
  - opcode_t enum (R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI)
  - imm_fmt_t enum (I, S, B, U, J, SHAMT)
  - ALU control constants
  - ctrl_t packed struct of the decode_* control bits
- One sub-module, regfile_2r1w (parameters XLEN, NREGS), holding the registers, x0 rule and synchronous reset.
- Decode logic, handshake, bypass and snoop stay in stage_decode_pipe.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), ex_ready=1 → next cycle decode_valid=1, imm=0xFFFFFFFB, alu_src=1, wr_enable=1, rd=1.
- Hold ex_ready=0 for 3 cycles with a new fetch_valid → fetch_ready=0, outputs unchanged; on ex_ready=1 the held instruction leaves first, then the new one.
- Transfer reads x5 while wb writes x5=0x1234 → rs_data1=0x1234 with WB_BYPASS=1, and old value with WB_BYPASS=0. While stalled with rs1=x5, wb writes x5=0xBEEF → held rs_data1 becomes 0xBEEF.
- BEQ with offset -8 → decode_branch=1, imm=0xFFFFFFF8. JAL with +2048 → jump=1, jal_src=1, imm=0x800.
- flush together with a fetch transfer → decode_valid=0 the next cycle. Assert rst mid-stall → all outputs 0 and x1 reads 0.
- NREGS=16, ADD x20,x1,x2 → decode_illegal=1, wr_enable=0. Opcode 0x7F → decode_illegal=1.
